mult_seq_param: RTL and testbench

- Parametrised sequential shift-add multiplier; successor to the fixed 8-bit multiplier block.
- Adds:
  - generic operand width
  - signed/unsigned mode select
  - Busy status
  - one-cycle Ready pulse
  - exact 2*WIDTH product
- Sits in the arithmetic datapath; driven by a controller through a Start/Ready handshake.

---
 rtl/mult_seq_param.sv | 126 ++++++++++++
 tb/tb_mult_seq_param.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// Parametrised sequential shift-add multiplier with signed/unsigned mode and a Start/Ready handshake.
// Optional macro ZERO_SKIP_EN: a zero operand sends IDLE straight to DONE, so the result arrives one edge after Start.
module mult_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    output logic [2*WIDTH-1:0] Producto,
    output logic               Ready,
    output logic               Busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   mcand;
    logic               neg;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
`ifdef ZERO_SKIP_EN
    logic               zero_op;
`endif

    // Operate on magnitudes only; the sign is applied once to the finished product.
    // Negating -2^(WIDTH-1) gives 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    always_comb begin
        sign_a = Signed_Mode & Multiplicando[WIDTH-1];
        sign_b = Signed_Mode & Multiplicador[WIDTH-1];
        mag_a  = sign_a ? -Multiplicando : Multiplicando;
        mag_b  = sign_b ? -Multiplicador : Multiplicador;
        sum    = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : '0);
        prod   = {acc_hi, mplr};
`ifdef ZERO_SKIP_EN
        zero_op = (Multiplicando == '0) || (Multiplicador == '0);
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The counter is loaded with WIDTH, so leaving RUN when it reads 1 gives exactly WIDTH iterations.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (Start) begin
`ifdef ZERO_SKIP_EN
                    stateNext = zero_op ? DONE : RUN;
`else
                    stateNext = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // Datapath: the multiplier shares its register with the low half of the product.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt      <= '0;
            acc_hi   <= '0;
            mplr     <= '0;
            mcand    <= '0;
            neg      <= 1'b0;
            Producto <= '0;
            Ready    <= 1'b0;
        end else begin
            Ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand  <= mag_a;
                        mplr   <= mag_b;
                        acc_hi <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        neg    <= sign_a ^ sign_b;
`ifdef ZERO_SKIP_EN
                        if (zero_op) begin
                            mplr <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    acc_hi <= sum[WIDTH:1];
                    mplr   <= {sum[0], mplr[WIDTH-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                end
                DONE: begin
                    Producto <= neg ? -prod : prod;
                    Ready    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param: an 8-bit instance and a 16-bit instance share clock and reset.
// Expected zero-operand latency follows ZERO_SKIP_EN when the bench is built with that macro.
module tb_mult_seq_param;

`ifdef ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 9;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        start8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [15:0] prod8;
    logic        ready8;
    logic        busy8;
    logic        start16 = 1'b0;
    logic        sm16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [31:0] prod16;
    logic        ready16;
    logic        busy16;

    int compared = 0;
    int mismatched = 0;

    mult_seq_param #(.WIDTH(8)) u8 (
        .Clock(Clock), .Reset(Reset), .Start(start8), .Signed_Mode(sm8),
        .Multiplicando(a8), .Multiplicador(b8),
        .Producto(prod8), .Ready(ready8), .Busy(busy8)
    );

    mult_seq_param #(.WIDTH(16)) u16 (
        .Clock(Clock), .Reset(Reset), .Start(start16), .Signed_Mode(sm16),
        .Multiplicando(a16), .Multiplicador(b16),
        .Producto(prod16), .Ready(ready16), .Busy(busy16)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issues one Start on the 8-bit unit and waits (bounded) for Ready; reports latency and Busy length.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                 output int cyc, output logic [15:0] p, output int busyCyc);
        a8 = a;
        b8 = b;
        sm8 = sm;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 0;
        busyCyc = 0;
        while (cyc < 40) begin
            if (busy8) busyCyc++;
            tick();
            cyc++;
            if (ready8) break;
        end
        p = prod8;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        compared++;
        if (prod8 !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_prod8: got %h expected %h", prod8, 16'h0000);
        end
        compared++;
        if (ready8 !== 1'b0 || busy8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags8: got ready=%b busy=%b expected 0 0", ready8, busy8);
        end
        compared++;
        if (prod16 !== 32'h0 || ready16 !== 1'b0 || busy16 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_u16: got prod=%h ready=%b busy=%b expected 0 0 0", prod16, ready16, busy16);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        int cyc;
        int busyCyc;
        logic [15:0] p;
        applyStimulus(8'hDF, 8'hD7, 1'b0, cyc, p, busyCyc);
        compared++;
        if (cyc !== 9) begin
            mismatched++;
            $display("[TB] FAIL unsigned_latency: got %0d expected %0d", cyc, 9);
        end
        compared++;
        if (p !== 16'hBB49) begin
            mismatched++;
            $display("[TB] FAIL unsigned_prod: got %h expected %h", p, 16'hBB49);
        end
        compared++;
        if (busyCyc !== 9) begin
            mismatched++;
            $display("[TB] FAIL unsigned_busy_len: got %0d expected %0d", busyCyc, 9);
        end
        compared++;
        if (busy8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL unsigned_busy_in_ready: got %b expected %b", busy8, 1'b0);
        end
        tick();
        compared++;
        if (ready8 !== 1'b0 || prod8 !== 16'hBB49) begin
            mismatched++;
            $display("[TB] FAIL unsigned_ready_pulse: got ready=%b prod=%h expected 0 bb49", ready8, prod8);
        end
        applyStimulus(8'hFF, 8'hFF, 1'b0, cyc, p, busyCyc);
        compared++;
        if (p !== 16'hFE01) begin
            mismatched++;
            $display("[TB] FAIL unsigned_ff: got %h expected %h", p, 16'hFE01);
        end
        tick();
    endtask

    task automatic test_signed();
        int cyc;
        int busyCyc;
        logic [15:0] p;
        applyStimulus(8'hDF, 8'hD7, 1'b1, cyc, p, busyCyc);
        compared++;
        if (p !== 16'h0549 || cyc !== 9) begin
            mismatched++;
            $display("[TB] FAIL signed_neg_neg: got %h lat %0d expected %h lat 9", p, cyc, 16'h0549);
        end
        tick();
        applyStimulus(8'h80, 8'h7F, 1'b1, cyc, p, busyCyc);
        compared++;
        if (p !== 16'hC080) begin
            mismatched++;
            $display("[TB] FAIL signed_min_max: got %h expected %h", p, 16'hC080);
        end
        tick();
        applyStimulus(8'h80, 8'h80, 1'b1, cyc, p, busyCyc);
        compared++;
        if (p !== 16'h4000) begin
            mismatched++;
            $display("[TB] FAIL signed_min_min: got %h expected %h", p, 16'h4000);
        end
        tick();
        applyStimulus(8'h05, 8'hFD, 1'b1, cyc, p, busyCyc);
        compared++;
        if (p !== 16'hFFF1) begin
            mismatched++;
            $display("[TB] FAIL signed_pos_neg: got %h expected %h", p, 16'hFFF1);
        end
        tick();
        applyStimulus(8'hFF, 8'hFF, 1'b1, cyc, p, busyCyc);
        compared++;
        if (p !== 16'h0001) begin
            mismatched++;
            $display("[TB] FAIL signed_m1_m1: got %h expected %h", p, 16'h0001);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int times[3];
        logic [15:0] prods[3];
        int readyCount;
        int expTimes[3];
        expTimes = '{9, 19, 29};
        times = '{0, 0, 0};
        prods = '{16'h0, 16'h0, 16'h0};
        readyCount = 0;
        a8 = 8'hFF;
        b8 = 8'hFF;
        sm8 = 1'b0;
        start8 = 1'b1;
        tick();
        for (int c = 1; c <= 29; c++) begin
            tick();
            if (ready8) begin
                if (readyCount < 3) begin
                    times[readyCount] = c;
                    prods[readyCount] = prod8;
                end
                readyCount++;
            end
            if (c == 29) start8 = 1'b0;
        end
        compared++;
        if (readyCount !== 3) begin
            mismatched++;
            $display("[TB] FAIL b2b_ready_count: got %0d expected %0d", readyCount, 3);
        end
        for (int j = 0; j < 3; j++) begin
            compared++;
            if (times[j] !== expTimes[j] || prods[j] !== 16'hFE01) begin
                mismatched++;
                $display("[TB] FAIL b2b_job%0d: got cycle %0d prod %h expected cycle %0d prod fe01",
                         j, times[j], prods[j], expTimes[j]);
            end
        end
        tick();
        compared++;
        if (busy8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_no_fourth_job: got busy=%b expected %b", busy8, 1'b0);
        end
    endtask

    task automatic test_reset_midop();
        int readies;
        int cyc;
        int busyCyc;
        logic [15:0] p;
        a8 = 8'hDF;
        b8 = 8'hD7;
        sm8 = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        Reset = 1'b0;
        tick();
        compared++;
        if (prod8 !== 16'h0000 || ready8 !== 1'b0 || busy8 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midop_reset: got prod=%h ready=%b busy=%b expected 0000 0 0", prod8, ready8, busy8);
        end
        Reset = 1'b1;
        readies = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (ready8) readies++;
        end
        compared++;
        if (readies !== 0) begin
            mismatched++;
            $display("[TB] FAIL midop_no_ready: got %0d pulses expected %0d", readies, 0);
        end
        applyStimulus(8'hDF, 8'hD7, 1'b0, cyc, p, busyCyc);
        compared++;
        if (p !== 16'hBB49 || cyc !== 9) begin
            mismatched++;
            $display("[TB] FAIL midop_rerun: got %h lat %0d expected bb49 lat 9", p, cyc);
        end
        tick();
    endtask

    task automatic test_width16();
        int cyc;
        a16 = 16'hFFFF;
        b16 = 16'h0003;
        sm16 = 1'b0;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        a16 = 16'h1234;
        b16 = 16'h00FF;
        sm16 = 1'b1;
        cyc = 0;
        while (cyc < 60) begin
            tick();
            cyc++;
            if (ready16) break;
        end
        compared++;
        if (cyc !== 17) begin
            mismatched++;
            $display("[TB] FAIL w16_latency: got %0d expected %0d", cyc, 17);
        end
        compared++;
        if (prod16 !== 32'h0002FFFD) begin
            mismatched++;
            $display("[TB] FAIL w16_prod: got %h expected %h", prod16, 32'h0002FFFD);
        end
        tick();
    endtask

    task automatic test_zero();
        int cyc;
        int busyCyc;
        logic [15:0] p;
        applyStimulus(8'h00, 8'h5A, 1'b0, cyc, p, busyCyc);
        compared++;
        if (cyc !== ZERO_LAT || p !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL zero_a: got lat %0d prod %h expected lat %0d prod 0000", cyc, p, ZERO_LAT);
        end
        compared++;
        if (busyCyc !== ZERO_LAT) begin
            mismatched++;
            $display("[TB] FAIL zero_busy_len: got %0d expected %0d", busyCyc, ZERO_LAT);
        end
        tick();
        applyStimulus(8'h33, 8'h44, 1'b0, cyc, p, busyCyc);
        compared++;
        if (p !== 16'h0D8C || cyc !== 9) begin
            mismatched++;
            $display("[TB] FAIL nonzero_after_zero: got %h lat %0d expected 0d8c lat 9", p, cyc);
        end
        tick();
        applyStimulus(8'h85, 8'h00, 1'b1, cyc, p, busyCyc);
        compared++;
        if (cyc !== ZERO_LAT || p !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL zero_b_signed: got lat %0d prod %h expected lat %0d prod 0000", cyc, p, ZERO_LAT);
        end
        tick();
    endtask

    initial begin
        $display("[TB] mult_seq_param directed bench, zero-operand latency %0d", ZERO_LAT);
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_midop();
        test_width16();
        test_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
